// File: rtl/dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// dmem_core_if / dmem_mem_if : core-side request/response and memory-side
// handshake bundles for dmem_bridge.  Revision: 1.0
// ============================================================================

interface dmem_core_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        acc_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  stall, rsp_valid, rsp_rdata, acc_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output stall, rsp_valid, rsp_rdata, acc_err
  );
endinterface

interface dmem_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_mask,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_mask,
    output mem_ready, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// dmem_bridge : RV32I load/store to word-wide memory bridge (1-2 beats).
// Define DMEM_MISALIGN_EN to support misaligned H/W.  Revision: 1.0
// ============================================================================

module dmem_bridge (
  input  logic       clk,
  input  logic       reset,
  dmem_core_if.slave core,
  dmem_mem_if.master mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        op_we;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_err;
  logic [31:0] rd_lo;
  logic [31:0] rd_hi;

  logic        funct3_bad;
  logic        misalign;
  logic        req_err;
  logic [1:0]  offset;
  logic [7:0]  mask8;
  logic [63:0] wdata64;
  logic        spans;
  logic [31:0] load_raw;
  logic [31:0] load_ext;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  assign funct3_bad = (core.req_funct3 == 3'b011) || (core.req_funct3[2:1] == 2'b11);

`ifdef DMEM_MISALIGN_EN
  assign misalign = 1'b0;
  assign spans    = |mask8[7:4];
`else
  assign misalign = ((core.req_funct3[1:0] == 2'b01) && core.req_addr[0]) ||
                    ((core.req_funct3[1:0] == 2'b10) && (core.req_addr[1:0] != 2'b00));
  assign spans    = 1'b0;
`endif

  assign req_err = funct3_bad | misalign;
  assign offset  = op_addr[1:0];
  assign mask8   = {4'b0000, size_mask(op_funct3[1:0])} << offset;
  assign wdata64 = {32'h0, op_wdata} << {offset, 3'b000};

  // Both beats are concatenated so a spanning access can be realigned by one shift.
  assign load_raw = 32'({rd_hi, rd_lo} >> {offset, 3'b000});

  always_comb begin
    case (op_funct3)
      3'b000:  load_ext = {{24{load_raw[7]}}, load_raw[7:0]};
      3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
      3'b100:  load_ext = {24'h0, load_raw[7:0]};
      3'b101:  load_ext = {16'h0, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    core.stall     = 1'b0;
    core.rsp_valid = 1'b0;
    core.rsp_rdata = 32'h0;
    core.acc_err   = 1'b0;
    mem.mem_valid  = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = 32'h0;
    mem.mem_wdata  = 32'h0;
    mem.mem_mask   = 4'h0;
    case (state)
      IDLE: begin
        core.stall = core.req_valid & ~reset;
        if (core.req_valid) begin
          state_nxt = req_err ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        core.stall    = 1'b1;
        mem.mem_valid = 1'b1;
        mem.mem_we    = op_we;
        mem.mem_addr  = {op_addr[31:2], 2'b00};
        mem.mem_wdata = wdata64[31:0];
        mem.mem_mask  = mask8[3:0];
        if (mem.mem_ready) begin
          state_nxt = spans ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        core.stall    = 1'b1;
        mem.mem_valid = 1'b1;
        mem.mem_we    = op_we;
        mem.mem_addr  = {op_addr[31:2], 2'b00} + 32'd4;
        mem.mem_wdata = wdata64[63:32];
        mem.mem_mask  = mask8[7:4];
        if (mem.mem_ready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        core.rsp_valid = 1'b1;
        core.rsp_rdata = (op_we || op_err) ? 32'h0 : load_ext;
        core.acc_err   = op_err;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_we     <= 1'b0;
      op_funct3 <= 3'b000;
      op_addr   <= 32'h0;
      op_wdata  <= 32'h0;
      op_err    <= 1'b0;
      rd_lo     <= 32'h0;
      rd_hi     <= 32'h0;
    end else begin
      if ((state == IDLE) && core.req_valid) begin
        op_we     <= core.req_we;
        op_funct3 <= core.req_funct3;
        op_addr   <= core.req_addr;
        op_wdata  <= core.req_wdata;
        op_err    <= req_err;
        rd_lo     <= 32'h0;
        rd_hi     <= 32'h0;
      end
      if ((state == BEAT0) && mem.mem_ready) begin
        rd_lo <= mem.mem_rdata;
      end
      if ((state == BEAT1) && mem.mem_ready) begin
        rd_hi <= mem.mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// tb_dmem_bridge : directed scoreboard bench for dmem_bridge.  Revision: 1.0
// ============================================================================

module tb_dmem_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_core_if core ();
  dmem_mem_if  mem ();

  dmem_bridge dut (
    .clk   (clk),
    .reset (reset),
    .core  (core.slave),
    .mem   (mem.master)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request, models memory with 'waits' not-ready cycles per beat,
  // and checks every beat and the response against the given expectations.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input int waits, input int nb,
                     input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
                     input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1,
                     input logic [31:0] erd, input logic eerr, input int lat);
    int   cyc;
    int   beat;
    int   wcnt;
    bit   done;
    rsp_t r;
    @(negedge clk);
    core.req_valid  = 1'b1;
    core.req_we     = we;
    core.req_funct3 = f3;
    core.req_addr   = a;
    core.req_wdata  = wd;
    sb.push_back({eerr, erd});
    cyc  = 1;
    beat = 0;
    wcnt = 0;
    done = 1'b0;
    while (!done && cyc <= 20) begin
      mem.mem_ready = (wcnt >= waits);
      mem.mem_rdata = !mem.mem_ready ? 32'hBAD0BAD0 : ((beat == 0) ? d0 : d1);
      #2;
      chk({tag, ":stall"}, core.stall, (cyc != lat));
      if (mem.mem_valid === 1'b1) begin
        chk({tag, ":beat_expected"}, (beat < nb), 1'b1);
        if (beat < nb) begin
          chk({tag, ":mem_we"}, mem.mem_we, we);
          chk({tag, ":mem_addr"}, mem.mem_addr, (beat == 0) ? a0 : a1);
          chk({tag, ":mem_mask"}, mem.mem_mask, (beat == 0) ? m0 : m1);
          chk({tag, ":mem_wdata"}, mem.mem_wdata, (beat == 0) ? w0 : w1);
        end
        if (mem.mem_ready) begin
          beat++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (core.rsp_valid === 1'b1) begin
        chk({tag, ":sb_nonempty"}, (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
          r = sb.pop_front();
          chk({tag, ":rsp_rdata"}, core.rsp_rdata, r.rdata);
          chk({tag, ":acc_err"}, core.acc_err, r.err);
        end
        chk({tag, ":latency"}, cyc, lat);
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    core.req_valid = 1'b0;
    mem.mem_ready  = 1'b0;
    chk({tag, ":rsp_seen"}, done, 1'b1);
    chk({tag, ":beats"}, beat, nb);
    #2;
    chk({tag, ":idle_stall"}, core.stall, 1'b0);
    chk({tag, ":idle_mem_valid"}, mem.mem_valid, 1'b0);
    chk({tag, ":idle_rsp_valid"}, core.rsp_valid, 1'b0);
  endtask

  initial begin
    reset           = 1'b1;
    core.req_valid  = 1'b1;
    core.req_we     = 1'b1;
    core.req_funct3 = 3'b010;
    core.req_addr   = 32'h100;
    core.req_wdata  = 32'hFFFFFFFF;
    mem.mem_ready   = 1'b1;
    mem.mem_rdata   = 32'h0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst:stall", core.stall, 1'b0);
    chk("rst:mem_valid", mem.mem_valid, 1'b0);
    chk("rst:rsp_valid", core.rsp_valid, 1'b0);
    chk("rst:mem_mask", mem.mem_mask, 4'h0);
    chk("rst:mem_addr", mem.mem_addr, 32'h0);
    core.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    txn("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1,
        32'h100, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    txn("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 1,
        32'h100, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    txn("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 1,
        32'h100, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080, 1'b0, 3);
    txn("sh_202", 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 32'h0, 2, 1,
        32'h200, 4'b1100, 32'hABCD0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 5);
    txn("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017777, 32'h0, 0, 1,
        32'h100, 4'b1100, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 3);
    txn("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80017777, 32'h0, 0, 1,
        32'h100, 4'b1100, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00008001, 1'b0, 3);
    txn("sb_101", 1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0, 32'h0, 1, 1,
        32'h100, 4'b0010, 32'h34567800, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 4);
    txn("sw_400", 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 32'h0, 0, 1,
        32'h400, 4'b1111, 32'hCAFEF00D, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 3);
    txn("f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h11111111, 32'h0, 0, 0,
        32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2);
    txn("f3_110", 1'b1, 3'b110, 32'h104, 32'h5555AAAA, 32'h0, 32'h0, 0, 0,
        32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2);
    txn("f3_111", 1'b0, 3'b111, 32'h108, 32'h0, 32'h22222222, 32'h0, 0, 0,
        32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2);
`ifdef DMEM_MISALIGN_EN
    txn("lw_301", 1'b0, 3'b010, 32'h301, 32'h0, 32'h44332211, 32'h88776655, 0, 2,
        32'h300, 4'b1110, 32'h0, 32'h304, 4'b0001, 32'h0, 32'h55443322, 1'b0, 4);
    txn("sh_203", 1'b1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0, 32'h0, 1, 2,
        32'h200, 4'b1000, 32'hEF000000, 32'h204, 4'b0001, 32'h000000BE, 32'h0, 1'b0, 6);
    txn("lh_101", 1'b0, 3'b001, 32'h101, 32'h0, 32'hAABBCCDD, 32'h0, 0, 1,
        32'h100, 4'b0110, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFBBCC, 1'b0, 3);
`else
    txn("lw_301", 1'b0, 3'b010, 32'h301, 32'h0, 32'h44332211, 32'h88776655, 0, 0,
        32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2);
    txn("sh_203", 1'b1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0, 32'h0, 1, 0,
        32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2);
    txn("lh_101", 1'b0, 3'b001, 32'h101, 32'h0, 32'hAABBCCDD, 32'h0, 0, 0,
        32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2);
`endif

    // Abandon a load stuck in BEAT0 by asserting reset mid-cycle.
    @(negedge clk);
    core.req_valid  = 1'b1;
    core.req_we     = 1'b0;
    core.req_funct3 = 3'b010;
    core.req_addr   = 32'h500;
    core.req_wdata  = 32'h0;
    mem.mem_ready   = 1'b0;
    @(negedge clk);
    #2;
    chk("midrst:pre_mem_valid", mem.mem_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst:mem_valid", mem.mem_valid, 1'b0);
    chk("midrst:mem_addr", mem.mem_addr, 32'h0);
    chk("midrst:mem_mask", mem.mem_mask, 4'h0);
    chk("midrst:stall", core.stall, 1'b0);
    chk("midrst:rsp_valid", core.rsp_valid, 1'b0);
    core.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    txn("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 32'h13579BDF, 32'h0, 0, 1,
        32'h100, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 32'h13579BDF, 1'b0, 3);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 1, core load/store request present.
REQ-004 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-005 SHALL have port req_funct3, input, 3, RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 SHALL have port req_addr, input, 32, byte address (ALU result).
REQ-007 SHALL have port req_wdata, input, 32, store data, LSB-aligned (rs2).
REQ-008 SHALL have port stall, output, 1, core must hold PC and request.
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 32, extended load result (0 for stores).
REQ-011 SHALL have port acc_err, output, 1, access error, valid only with rsp_valid.
REQ-012 SHALL have ports mem_valid (output, 1), mem_ready (input, 1), mem_we (output, 1), mem_addr (output, 32, word-aligned), mem_wdata (output, 32), mem_mask (output, 4, byte enables), mem_rdata (input, 32).

Function
REQ-013 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-014 IDLE with req_valid=1 SHALL latch req_we/funct3/addr/wdata and move to BEAT0; on an error condition it SHALL move directly to RESP with no memory beat.
REQ-015 Error conditions SHALL be: funct3 in {011, 110, 111}; misalignment (H with addr[0]=1, W with addr[1:0]!=00) when DMEM_MISALIGN_EN is undefined.
REQ-016 BEAT0/BEAT1 SHALL assert mem_valid from registers and hold mem_we/addr/wdata/mask stable until the cycle in which mem_ready=1.
REQ-017 BEAT0 SHALL drive mem_addr = {addr[31:2],00}, mem_mask = (size mask << addr[1:0]) truncated to 4 bits, mem_wdata = wdata << 8*addr[1:0].
REQ-018 After BEAT0 handshake, if addr[1:0] + size > 4, the FSM SHALL go to BEAT1; otherwise to RESP.
REQ-019 BEAT1 SHALL drive mem_addr = {addr[31:2],00} + 4, mem_mask = spilled upper mask bits, mem_wdata = wdata >> 8*(4 - addr[1:0]); after handshake, go to RESP.
REQ-020 Load bytes SHALL be captured from mem_rdata at each handshake, assembled LSB-first, and sign-extended (B, H) or zero-extended (BU, HU) into rsp_rdata.
REQ-021 RESP SHALL assert rsp_valid=1 for exactly one cycle, with rsp_rdata and acc_err, then return unconditionally to IDLE.
REQ-022 On error, rsp_rdata SHALL be 0, acc_err SHALL be 1, and mem_valid SHALL never assert.
REQ-023 stall SHALL be combinational: 1 when (IDLE and req_valid) or in BEAT0/BEAT1; 0 in RESP and in IDLE without a request.
REQ-024 mem_we=1 with mem_ready=1 SHALL commit the store beat; store completion SHALL be reported through RESP like loads.
REQ-025 Aligned-access latency with mem_ready held high SHALL be 3 cycles from request to rsp_valid; a two-beat access SHALL take 4 cycles; each cycle with mem_ready low adds one cycle.
REQ-026 req_valid in RESP SHALL be ignored; the core re-presents the request in IDLE the following cycle.

Reset
REQ-027 Asserting reset at any time, including mid-beat, SHALL force IDLE and drive mem_valid, mem_we, mem_mask, mem_addr, mem_wdata, rsp_valid, rsp_rdata, acc_err and stall to 0; the in-flight transaction SHALL be abandoned.
REQ-028 The first request after reset deassertion SHALL be accepted on the first rising edge with req_valid=1.

Configuration
REQ-029 Macro DMEM_MISALIGN_EN defined: misaligned H/W accesses SHALL be supported (one beat if within the word, two beats if spanning), with acc_err=0.
REQ-030 Macro DMEM_MISALIGN_EN undefined: misaligned H/W SHALL raise acc_err per REQ-022; BEAT1 SHALL be unreachable and may be omitted.

Verification
REQ-031 LW addr 0x100, mem_ready=1, mem_rdata=0xDEADBEEF -> mem_mask=1111, rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, acc_err=0.
REQ-032 LB addr 0x103, mem_rdata=0x80xxxxxx -> mem_mask=1000, rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-033 SH addr 0x202, wdata=0x0000ABCD, mem_ready low for 2 cycles -> mem_wdata=0xABCD0000, mem_mask=1100 held stable; rsp_valid in cycle 5.
REQ-034 With DMEM_MISALIGN_EN: LW addr 0x301, beat data 0x44332211 then 0x88776655 -> beats at 0x300 mask 1110 and 0x304 mask 0001; rsp_rdata=0x55443322. Without the macro: no mem_valid, acc_err=1, rsp_rdata=0.
REQ-035 funct3=011 -> RESP next cycle with acc_err=1 and no mem_valid.
REQ-036 reset asserted during BEAT0 with mem_ready=0 -> mem_valid=0 immediately; a fresh LW afterwards completes normally.
